// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU ops, opcode/funct encodings, default widths and the
// decoded control bundle passed from decode into the ID/EX register.
package cpu_pkg;

    localparam int XLEN_DEF = 64;
    localparam int RA_W_DEF = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// Load-use hazard detection: a load sitting in EX whose rd is read by the
// instruction in decode. Purely combinational so a forwarding unit can reuse it.
module hazard_detect
    import cpu_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
) (
    input  logic            i_ex_valid,
    input  logic            i_ex_mem_read,
    input  logic [RA_W-1:0] i_ex_rd,
    input  logic            i_id_valid,
    input  logic [RA_W-1:0] i_id_rs1,
    input  logic [RA_W-1:0] i_id_rs2,
    input  logic            i_id_uses_rs2,
    output logic            o_load_use
);

    logic w_rd_nz;
    logic w_hit_rs1;
    logic w_hit_rs2;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_rd_nz    = (i_ex_rd != '0);
    assign w_hit_rs1  = (i_ex_rd == i_id_rs1);
    assign w_hit_rs2  = i_id_uses_rs2 & (i_ex_rd == i_id_rs2);
    assign o_load_use = i_ex_valid & i_ex_mem_read & w_rd_nz & i_id_valid
                      & (w_hit_rs1 | w_hit_rs2);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, EX backpressure and
// branch flush. Define ID_EX_STALL_CNT_EN to add stall_cnt/bubble_cnt counters.
module id_ex_pipe
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_uses_rs2,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_reg_write,
    input  logic            id_alu_src,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            id_branch,
    input  logic [2:0]      id_alu_op,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA_W-1:0] ex_rs1,
    output logic [RA_W-1:0] ex_rs2,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_alu_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic [2:0]      ex_alu_op
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     bubble_cnt
`endif
);

    // Handshake: the ex_* bundle is transferred on a rising edge where
    // ex_valid & ex_ready; while ex_valid & ~ex_ready the bundle is held stable.
    logic            r_valid;
    ctrl_t           r_ctrl;
    logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [RA_W-1:0] r_rs1, r_rs2, r_rd;

    logic  w_hold;
    logic  w_load_use;
    logic  w_bubble;
    logic  w_en;
    logic  w_clear;
    ctrl_t w_id_ctrl;

    hazard_detect #(.RA_W(RA_W)) u_hazard (
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rd       (r_rd),
        .i_id_valid    (id_valid),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_uses_rs2 (id_uses_rs2),
        .o_load_use    (w_load_use)
    );

    assign w_hold   = r_valid & ~ex_ready;
    assign id_stall = ~flush & (w_hold | w_load_use);
    assign w_bubble = ~flush & ~w_hold & w_load_use;

    // Flush outranks hold: the EX-resident instruction is the one redirecting.
    assign w_en    = flush | ~w_hold;
    assign w_clear = flush | w_load_use | ~id_valid;

    assign w_id_ctrl = '{reg_write:  id_reg_write,
                         alu_src:    id_alu_src,
                         alu_op:     id_alu_op,
                         mem_read:   id_mem_read,
                         mem_write:  id_mem_write,
                         mem_to_reg: id_mem_to_reg,
                         branch:     id_branch};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_ctrl     <= CTRL_NOP;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
        end else if (w_en) begin
            r_valid    <= ~w_clear;
            r_ctrl     <= w_clear ? CTRL_NOP : w_id_ctrl;
            r_pc       <= w_clear ? '0 : id_pc;
            r_rs1_data <= w_clear ? '0 : id_rs1_data;
            r_rs2_data <= w_clear ? '0 : id_rs2_data;
            r_imm      <= w_clear ? '0 : id_imm;
            r_rs1      <= w_clear ? '0 : id_rs1;
            r_rs2      <= w_clear ? '0 : id_rs2;
            r_rd       <= w_clear ? '0 : id_rd;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_rs1_data   = r_rs1_data;
    assign ex_rs2_data   = r_rs2_data;
    assign ex_imm        = r_imm;
    assign ex_rs1        = r_rs1;
    assign ex_rs2        = r_rs2;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_alu_src    = r_ctrl.alu_src;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign ex_branch     = r_ctrl.branch;
    assign ex_alu_op     = r_ctrl.alu_op;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Both counters saturate rather than wrap so long runs stay meaningful.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (id_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_bubble && !(&r_bubble_cnt))
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register with load-use hazard detection. Sits directly downstream of the decode control unit.
- Captures the decoded control bundle (reg_write, alu_src, alu_op, mem_read, mem_write, mem_to_reg, branch), operands, immediate and register indices.
- Presents the captured bundle to the execute stage one cycle later.
- Generates the decode-stage stall, inserts bubbles on load-use hazards, and honours execute backpressure and branch flush.

Parameters:
- XLEN, 64, datapath width of operands, immediate and PC
- RA_W, 5, register-index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  decode stage holds a valid instruction
- id_pc  in  XLEN  PC of decode instruction
- id_rs1, id_rs2, id_rd  in  RA_W  source/destination indices
- id_uses_rs2  in  1  instruction reads rs2 (R-type, SW, BEQ)
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_reg_write, id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  decoded control
- id_alu_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
- flush  in  1  branch taken in EX; kill the decode instruction
- ex_ready  in  1  execute stage accepts the current ex_* bundle this cycle
- id_stall  out  1  hold PC and IF/ID; combinational
- ex_valid  out  1  ex_* bundle valid
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  RA_W  registered copies
- ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered control
- ex_alu_op  out  3  registered ALU op

Behaviour:
- Reset: all ex_* outputs and ex_valid go to 0 immediately. id_stall evaluates to 0.
- Latency: 1 cycle from ID inputs to ex_* outputs when loading.
- Combinational terms:
  - hold = ex_valid & ~ex_ready
  - load_use = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)))
  - id_stall = ~flush & (hold | load_use)
- Per-clock update, highest priority first:
  1. flush: ex_valid <= 0 and all ex_* <= 0. Overrides hold, because the EX-resident instruction is the one redirecting.
  2. hold: all registers keep their values.
  3. load_use: insert a bubble; ex_valid <= 0 and all ex_* <= 0. The IF/ID instruction is retained by id_stall.
  4. else: ex_valid <= id_valid; ex_* <= id_*. If id_valid = 0, control fields are forced to 0 and data fields are don't-care (implementation zeroes them).
- Invariant: whenever ex_valid = 0, ex_reg_write, ex_mem_read, ex_mem_write and ex_branch are 0.
- A load-use stall lasts exactly one cycle when ex_ready = 1, because the bubble clears ex_mem_read.
- rd = 0 never triggers a hazard.
- Hazard comparisons use registered ex_rd against live id_rs*; no forwarding logic lives here.
- Reset mid-stall clears everything asynchronously. The first instruction after reset loads with no stall.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt [31:0]. It increments every cycle id_stall = 1 and saturates at 0xFFFFFFFF.
  - Adds output bubble_cnt [31:0]. It increments on each load-use bubble and saturates at 0xFFFFFFFF.
  - Both counters reset to 0 on rst.
- Undefined: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU op constants ALU_ADD..ALU_XOR
  - opcode and funct constants
  - XLEN and RA_W defaults
  - a ctrl_t bundle typedef (reg_write, alu_src, alu_op, mem_read, mem_write, mem_to_reg, branch) and CTRL_NOP = all zero
- One natural sub-module, hazard_detect: purely combinational load_use computation, reusable by a later forwarding unit.

Test Plan:
- Reset with valid ID inputs applied -> ex_valid = 0, all ex_* = 0, id_stall = 0. After release, ADD r3,r1,r2 loads next edge with ex_alu_op = 000 and ex_reg_write = 1.
- LW r5 in EX with ex_ready = 1; ID holds ADD r6,r5,r1 -> id_stall = 1 for exactly one cycle, then a bubble (ex_valid = 0, ex_reg_write = 0), then ADD loads with ex_rs1 = 5.
- LW r0 in EX; ID reads r0 -> no stall. LW r5 in EX; ID is ADDI r6,r7 with id_rs2 = 5 and id_uses_rs2 = 0 -> no stall.
- ex_ready = 0 for 3 cycles with SUB in EX -> ex_* stable and id_stall = 1 for all 3 cycles; on ex_ready = 1, the next ID instruction loads.
- flush = 1 asserted together with ex_ready = 0 and a pending load_use -> next cycle ex_valid = 0, controls 0, and id_stall = 0 during the flush cycle.
- With ID_EX_STALL_CNT_EN defined: 2 load-use events plus 3 hold cycles -> stall_cnt = 5, bubble_cnt = 2.
